// File: rtl/fifo_ctrl.sv
// fifo_ctrl: push/pop control stage in front of a 9-bit FIFO memory.
// Issues same-cycle write/read strobes and tracks occupancy.
// Reports full, empty and almost-full status, plus sticky overflow and underflow flags.
// A flush request re-clears the memory pointers through a one-cycle CLEAR state.
module fifo_ctrl #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  PushReq,
  input  logic                  PopReq,
  input  logic                  Flush,
  output logic                  Write,
  output logic                  WrInc,
  output logic                  Read,
  output logic                  RdInc,
  output logic                  WrPtrClr,
  output logic                  RdPtrClr,
  output logic                  RdValid,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostFull,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic                  rd_valid_reg, rd_valid_next;
  logic                  push_ok, pop_ok, ptr_clr;
  logic                  empty, full;

  // Status flags come only from the registered occupancy.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);

  // State and status registers; reset parks the block in CLEAR with everything cleared.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= CLEAR;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      rd_valid_reg  <= rd_valid_next;
    end
  end

  // Next-state and accept logic.
  // CLEAR lasts exactly one cycle and ignores all requests.
  // In RUN, a flush suppresses strobes and returns to CLEAR.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    push_ok        = 1'b0;
    pop_ok         = 1'b0;
    ptr_clr        = 1'b0;
    case (state_reg)
      CLEAR: begin
        ptr_clr    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (Flush) begin
          state_next     = CLEAR;
          count_next     = '0;
          overflow_next  = 1'b0;
          underflow_next = 1'b0;
        end else begin
          // Gating by full/empty blocks fall-through on an empty FIFO.
          // It also blocks a push into a full FIFO, even when a pop is accepted that cycle.
          push_ok = PushReq & ~full;
          pop_ok  = PopReq & ~empty;
          if (push_ok && !pop_ok) begin
            count_next = count_reg + ONE_C;
          end else if (pop_ok && !push_ok) begin
            count_next = count_reg - ONE_C;
          end
          if (PushReq && full) begin
            overflow_next = 1'b1;
          end
          if (PopReq && empty) begin
            underflow_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
    rd_valid_next = pop_ok;
  end

  assign Write      = push_ok;
  assign WrInc      = push_ok;
  assign Read       = pop_ok;
  assign RdInc      = pop_ok;
  assign WrPtrClr   = ptr_clr;
  assign RdPtrClr   = ptr_clr;
  assign RdValid    = rd_valid_reg;
  assign Count      = count_reg;
  assign Empty      = empty;
  assign Full       = full;
  assign AlmostFull = (count_reg >= AF_C);
  assign Overflow   = overflow_reg;
  assign Underflow  = underflow_reg;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl.
// The driver predicts each cycle's outputs from an occupancy-level model and queues them.
// The monitor compares the queued prediction with the DUT mid-cycle.
module tb_fifo_ctrl;

  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int AF_LEVEL = 6;

  logic          Clk;
  logic          Rst, PushReq, PopReq, Flush;
  logic          Write, WrInc, Read, RdInc, WrPtrClr, RdPtrClr, RdValid;
  logic [AW:0]   Count;
  logic          Empty, Full, AlmostFull, Overflow, Underflow;

  typedef struct packed {
    logic [5:0]  strobes;  // Write WrInc Read RdInc WrPtrClr RdPtrClr
    logic [AW:0] count;
    logic [5:0]  status;   // RdValid Empty Full AlmostFull Overflow Underflow
  } exp_t;

  exp_t sb_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;
  bit   stim_done  = 0;

  // Reference model state: occupancy and flags, held as plain integers/bits.
  int occ;
  bit in_clear, ovf, unf, rdv;

  fifo_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AF_LEVEL)) dut (
    .Clk(Clk), .Rst(Rst), .PushReq(PushReq), .PopReq(PopReq), .Flush(Flush),
    .Write(Write), .WrInc(WrInc), .Read(Read), .RdInc(RdInc),
    .WrPtrClr(WrPtrClr), .RdPtrClr(RdPtrClr), .RdValid(RdValid),
    .Count(Count), .Empty(Empty), .Full(Full), .AlmostFull(AlmostFull),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  task automatic model_reset();
    occ = 0; in_clear = 1; ovf = 0; unf = 0; rdv = 0;
  endtask

  // Drive one cycle of stimulus, queue its predicted outputs, then advance the model.
  task automatic do_cycle(input bit r, input bit p, input bit q, input bit f);
    exp_t e;
    bit acc_push, acc_pop;
    @(posedge Clk);
    #1;
    Rst = r; PushReq = p; PopReq = q; Flush = f;
    acc_push = !in_clear && !f && p && (occ < DEPTH);
    acc_pop  = !in_clear && !f && q && (occ > 0);
    e.strobes = {acc_push, acc_push, acc_pop, acc_pop, in_clear, in_clear};
    e.count   = (AW+1)'(occ);
    e.status  = {rdv, occ == 0, occ == DEPTH, occ >= AF_LEVEL, ovf, unf};
    sb_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      rdv = acc_pop;
      if (in_clear) begin
        in_clear = 0;
      end else if (f) begin
        in_clear = 1; occ = 0; ovf = 0; unf = 0;
      end else begin
        if (p && occ == DEPTH) ovf = 1;
        if (q && occ == 0) unf = 1;
        occ = occ + int'(acc_push) - int'(acc_pop);
      end
    end
  endtask

  task automatic repeat_cycle(input int n, input bit p, input bit q, input bit f);
    for (int i = 0; i < n; i++) do_cycle(0, p, q, f);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction, away from the clock edge.
  int cyc = 0;
  always @(negedge Clk) begin
    exp_t e;
    logic [5:0] act_strobes, act_status;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cyc++;
      act_strobes = {Write, WrInc, Read, RdInc, WrPtrClr, RdPtrClr};
      act_status  = {RdValid, Empty, Full, AlmostFull, Overflow, Underflow};
      $display("cyc %0d rst=%b push=%b pop=%b flush=%b strobes=%b count=%0d status=%b",
               cyc, Rst, PushReq, PopReq, Flush, act_strobes, Count, act_status);
      n_compared++;
      if (act_strobes !== e.strobes) begin
        n_failed++;
        $display("FAIL strobes cyc %0d: got %b want %b", cyc, act_strobes, e.strobes);
      end
      n_compared++;
      if (Count !== e.count) begin
        n_failed++;
        $display("FAIL count cyc %0d: got %0d want %0d", cyc, Count, e.count);
      end
      n_compared++;
      if (act_status !== e.status) begin
        n_failed++;
        $display("FAIL status cyc %0d: got %b want %b", cyc, act_status, e.status);
      end
    end
  end

  initial begin
    Rst = 1; PushReq = 0; PopReq = 0; Flush = 0;
    // First reset edge brings the DUT to a known state; checking starts after it.
    @(posedge Clk);
    #1;
    model_reset();
    do_cycle(1, 0, 0, 0);
    do_cycle(0, 1, 1, 1);          // CLEAR cycle: requests ignored
    // Fill past full, then drain past empty.
    repeat_cycle(9, 1, 0, 0);
    repeat_cycle(9, 0, 1, 0);
    // Simultaneous push and pop at empty, mid-level and full.
    do_cycle(0, 1, 1, 0);          // 0 -> 1
    repeat_cycle(2, 1, 0, 0);      // -> 3
    do_cycle(0, 1, 1, 0);          // stays 3
    repeat_cycle(5, 1, 0, 0);      // -> 8
    do_cycle(0, 1, 1, 0);          // -> 7
    // Flush at 5 with Overflow set and a push pending.
    repeat_cycle(2, 1, 0, 0);      // -> 8, then overflow
    repeat_cycle(3, 0, 1, 0);      // -> 5
    do_cycle(0, 1, 0, 1);          // flush cycle
    repeat_cycle(2, 1, 0, 0);      // CLEAR, then push -> 1
    // Reset in the middle of a push burst at 4.
    repeat_cycle(3, 1, 0, 0);      // -> 4
    do_cycle(1, 1, 0, 0);
    repeat_cycle(3, 1, 0, 0);
    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      do_cycle($urandom_range(0, 127) == 0,
               $urandom_range(0, 99) < bias,
               $urandom_range(0, 99) < (100 - bias),
               $urandom_range(0, 47) == 0);
    end
    stim_done = 1;
    repeat (2) @(posedge Clk);
    n_compared++;
    if (sb_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain: %0d predictions left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
